// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - NPC select encodings, sequencer states and decode kind codes
package pc_seq_pkg;

  typedef enum logic [1:0] {
    NPC_PC4    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JMP    = 2'b10,
    NPC_REG    = 2'b11
  } npc_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'b00,
    ST_FETCH    = 2'b01,
    ST_WAIT     = 2'b10,
    ST_REDIRECT = 2'b11
  } seq_state_e;

  localparam logic [1:0] KIND_SEQ    = 2'b00;
  localparam logic [1:0] KIND_BRANCH = 2'b01;
  localparam logic [1:0] KIND_JMP    = 2'b10;
  localparam logic [1:0] KIND_REG    = 2'b11;

  // Jumps always redirect; branches only when the condition holds.
  function automatic logic needs_redirect(input logic [1:0] kind, input logic taken);
    return (kind == KIND_JMP) || (kind == KIND_REG) || ((kind == KIND_BRANCH) && taken);
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// rtl/seq_down_counter.sv - loadable saturating down-counter with zero flag
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - next-PC sequencing controller (boot hold, fetch handshake, redirect, timeout)
// Optional PC_SEQ_STATS_EN adds saturating stall/redirect counters.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int RESET_HOLD  = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_ready,
  input  logic        dec_valid,
  input  logic [1:0]  dec_kind,
  input  logic        branch_taken,
  input  logic        hazard_stall,
  output logic [1:0]  npc_from,
  output logic        branch_test,
  output logic        stall,
  output logic        imem_req,
  output logic        flush,
  output logic        err
`ifdef PC_SEQ_STATS_EN
  ,
  output logic [15:0] stat_stalls,
  output logic [15:0] stat_redirects
`endif
);

  localparam int CNT_MAX = (RESET_HOLD > MEM_TIMEOUT) ? RESET_HOLD : MEM_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  // The first BOOT edge arms the counter, so it is loaded two short of the hold.
  localparam logic [CW-1:0] HOLD_LOAD = CW'((RESET_HOLD >= 2) ? (RESET_HOLD - 2) : 0);
  localparam logic [CW-1:0] TMO_LOAD  = CW'(MEM_TIMEOUT - 1);

  seq_state_e    state;
  logic          boot_armed;
  logic          cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic          cnt_dec;
  logic          cnt_zero;
  logic          redirect_go;

  assign redirect_go = (state == ST_FETCH) && imem_ready && !hazard_stall && dec_valid &&
                       needs_redirect(dec_kind, branch_taken);

  assign cnt_load     = ((state == ST_BOOT) && !boot_armed) || ((state == ST_FETCH) && !imem_ready);
  assign cnt_load_val = (state == ST_BOOT) ? HOLD_LOAD : TMO_LOAD;
  assign cnt_dec      = ((state == ST_BOOT) && boot_armed) || (state == ST_WAIT);

  seq_down_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      boot_armed <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          boot_armed <= 1'b1;
          if ((!boot_armed && (RESET_HOLD == 1)) || (boot_armed && cnt_zero)) begin
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!imem_ready) begin
            state <= ST_WAIT;
          end else if (redirect_go) begin
            state <= ST_REDIRECT;
          end
        end
        ST_WAIT: begin
          // Ready in the final counted cycle wins over the timeout.
          if (imem_ready) begin
            state <= ST_FETCH;
          end else if (cnt_zero) begin
            err   <= 1'b1;
            state <= ST_FETCH;
          end
        end
        ST_REDIRECT: state <= ST_FETCH;
        default:     state <= ST_BOOT;
      endcase
    end
  end

  always_comb begin
    npc_from    = NPC_PC4;
    branch_test = 1'b0;
    stall       = 1'b0;
    imem_req    = 1'b0;
    flush       = 1'b0;
    case (state)
      ST_BOOT: stall = 1'b1;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (!imem_ready || hazard_stall) begin
          stall = 1'b1;
        end else if (dec_valid && (dec_kind != KIND_SEQ)) begin
          npc_from    = dec_kind;
          branch_test = branch_taken;
        end
      end
      ST_WAIT: begin
        stall    = 1'b1;
        imem_req = 1'b1;
      end
      ST_REDIRECT: begin
        stall = 1'b1;
        flush = 1'b1;
      end
      default: stall = 1'b1;
    endcase
  end

`ifdef PC_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stalls    <= 16'd0;
      stat_redirects <= 16'd0;
    end else begin
      if (stall && (state != ST_BOOT) && (stat_stalls != 16'hFFFF)) begin
        stat_stalls <= stat_stalls + 16'd1;
      end
      if (redirect_go && (stat_redirects != 16'hFFFF)) begin
        stat_redirects <= stat_redirects + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - scoreboard bench for pc_seq_ctrl
module tb_pc_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       imem_ready;
  logic       dec_valid;
  logic [1:0] dec_kind;
  logic       branch_taken;
  logic       hazard_stall;
  logic [1:0] npc_from;
  logic       branch_test;
  logic       stall;
  logic       imem_req;
  logic       flush;
  logic       err;
`ifdef PC_SEQ_STATS_EN
  logic [15:0] stat_stalls;
  logic [15:0] stat_redirects;
`endif

  int checks;
  int failures;
  logic [6:0] sb[$];

  // Expected output vectors {npc_from, branch_test, stall, imem_req, flush, err}
  localparam logic [6:0] E_BOOT   = 7'b00_0_1_0_0_0;
  localparam logic [6:0] E_FETCH  = 7'b00_0_0_1_0_0;
  localparam logic [6:0] E_HOLD   = 7'b00_0_1_1_0_0;
  localparam logic [6:0] E_REDIR  = 7'b00_0_1_0_1_0;
  localparam logic [6:0] E_JMP    = 7'b10_0_0_1_0_0;
  localparam logic [6:0] E_REG    = 7'b11_0_0_1_0_0;
  localparam logic [6:0] E_BR_NT  = 7'b01_0_0_1_0_0;
  localparam logic [6:0] E_BR_T   = 7'b01_1_0_1_0_0;
  localparam logic [6:0] E_ERRBIT = 7'b00_0_0_0_0_1;

  pc_seq_ctrl #(.RESET_HOLD(2), .MEM_TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_ready   (imem_ready),
    .dec_valid    (dec_valid),
    .dec_kind     (dec_kind),
    .branch_taken (branch_taken),
    .hazard_stall (hazard_stall),
    .npc_from     (npc_from),
    .branch_test  (branch_test),
    .stall        (stall),
    .imem_req     (imem_req),
    .flush        (flush),
    .err          (err)
`ifdef PC_SEQ_STATS_EN
    ,
    .stat_stalls    (stat_stalls),
    .stat_redirects (stat_redirects)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] obs();
    return {npc_from, branch_test, stall, imem_req, flush, err};
  endfunction

  // Row = {imem_ready, dec_valid, dec_kind, branch_taken, hazard_stall, expected[6:0]}
  function automatic logic [12:0] row(input logic rdy, input logic dv, input logic [1:0] k,
                                      input logic tk, input logic hz, input logic [6:0] e);
    return {rdy, dv, k, tk, hz, e};
  endfunction

  task automatic test_reset();
    logic [6:0] got;
    logic [6:0] want;
    rst_n = 1'b0;
    {imem_ready, dec_valid, dec_kind, branch_taken, hazard_stall} = '0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(E_BOOT);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL reset[%0d] got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_boot();
    logic [12:0] rows[$];
    logic [6:0]  got;
    logic [6:0]  want;
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    imem_ready = 1'b1;
    rows.push_back(row(1, 0, 2'b00, 0, 0, E_BOOT));
    rows.push_back(row(1, 0, 2'b00, 0, 0, E_BOOT));
    rows.push_back(row(1, 0, 2'b00, 0, 0, E_FETCH));
    foreach (rows[i]) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      {imem_ready, dec_valid, dec_kind, branch_taken, hazard_stall} = rows[i][12:7];
      sb.push_back(rows[i][6:0]);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL boot[%0d] got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_jump();
    logic [12:0] rows[$];
    logic [6:0]  got;
    logic [6:0]  want;
    rows.push_back(row(1, 1, 2'b10, 0, 0, E_JMP));
    rows.push_back(row(1, 0, 2'b00, 0, 0, E_REDIR));
    rows.push_back(row(1, 0, 2'b00, 0, 0, E_FETCH));
    foreach (rows[i]) begin
      @(posedge clk);
      #1;
      {imem_ready, dec_valid, dec_kind, branch_taken, hazard_stall} = rows[i][12:7];
      sb.push_back(rows[i][6:0]);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL jump[%0d] got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_branch();
    logic [12:0] rows[$];
    logic [6:0]  got;
    logic [6:0]  want;
    rows.push_back(row(1, 1, 2'b01, 0, 0, E_BR_NT));
    rows.push_back(row(1, 0, 2'b01, 1, 0, E_FETCH));
    rows.push_back(row(1, 1, 2'b01, 1, 0, E_BR_T));
    rows.push_back(row(1, 0, 2'b00, 0, 0, E_REDIR));
    rows.push_back(row(1, 0, 2'b00, 0, 0, E_FETCH));
    foreach (rows[i]) begin
      @(posedge clk);
      #1;
      {imem_ready, dec_valid, dec_kind, branch_taken, hazard_stall} = rows[i][12:7];
      sb.push_back(rows[i][6:0]);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL branch[%0d] got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] rows[$];
    logic [6:0]  got;
    logic [6:0]  want;
    rows.push_back(row(1, 1, 2'b11, 0, 0, E_REG));
    rows.push_back(row(1, 1, 2'b10, 0, 0, E_REDIR));
    rows.push_back(row(1, 1, 2'b10, 0, 0, E_JMP));
    rows.push_back(row(1, 0, 2'b00, 0, 0, E_REDIR));
    rows.push_back(row(1, 0, 2'b00, 0, 0, E_FETCH));
    foreach (rows[i]) begin
      @(posedge clk);
      #1;
      {imem_ready, dec_valid, dec_kind, branch_taken, hazard_stall} = rows[i][12:7];
      sb.push_back(rows[i][6:0]);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL back_to_back[%0d] got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_hazard();
    logic [12:0] rows[$];
    logic [6:0]  got;
    logic [6:0]  want;
    rows.push_back(row(1, 1, 2'b11, 0, 1, E_HOLD));
    rows.push_back(row(1, 1, 2'b11, 0, 1, E_HOLD));
    rows.push_back(row(1, 1, 2'b11, 0, 0, E_REG));
    rows.push_back(row(1, 0, 2'b00, 0, 0, E_REDIR));
    rows.push_back(row(1, 0, 2'b00, 0, 0, E_FETCH));
    foreach (rows[i]) begin
      @(posedge clk);
      #1;
      {imem_ready, dec_valid, dec_kind, branch_taken, hazard_stall} = rows[i][12:7];
      sb.push_back(rows[i][6:0]);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL hazard[%0d] got=%b want=%b", i, got, want);
      end
    end
  endtask

  // Ready arrives in the 15th WAIT cycle: success, no error.
  task automatic test_ready_late();
    logic [12:0] rows[$];
    logic [6:0]  got;
    logic [6:0]  want;
    rows.push_back(row(0, 1, 2'b10, 0, 0, E_HOLD));
    for (int n = 1; n <= 14; n++) rows.push_back(row(0, 0, 2'b00, 0, 0, E_HOLD));
    rows.push_back(row(1, 0, 2'b00, 0, 0, E_HOLD));
    rows.push_back(row(1, 0, 2'b00, 0, 0, E_FETCH));
    foreach (rows[i]) begin
      @(posedge clk);
      #1;
      {imem_ready, dec_valid, dec_kind, branch_taken, hazard_stall} = rows[i][12:7];
      sb.push_back(rows[i][6:0]);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL ready_late[%0d] got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_timeout();
    logic [12:0] rows[$];
    logic [6:0]  got;
    logic [6:0]  want;
    rows.push_back(row(0, 0, 2'b00, 0, 0, E_HOLD));
    for (int n = 1; n <= 15; n++) rows.push_back(row(0, 0, 2'b00, 0, 0, E_HOLD));
    rows.push_back(row(1, 0, 2'b00, 0, 0, E_FETCH | E_ERRBIT));
    rows.push_back(row(1, 1, 2'b01, 0, 0, E_BR_NT | E_ERRBIT));
    foreach (rows[i]) begin
      @(posedge clk);
      #1;
      {imem_ready, dec_valid, dec_kind, branch_taken, hazard_stall} = rows[i][12:7];
      sb.push_back(rows[i][6:0]);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL timeout[%0d] got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [12:0] rows[$];
    logic [6:0]  got;
    logic [6:0]  want;
    rows.push_back(row(0, 0, 2'b00, 0, 0, E_HOLD | E_ERRBIT));
    rows.push_back(row(0, 0, 2'b00, 0, 0, E_HOLD | E_ERRBIT));
    rows.push_back(row(0, 0, 2'b00, 0, 0, E_HOLD | E_ERRBIT));
    foreach (rows[i]) begin
      @(posedge clk);
      #1;
      {imem_ready, dec_valid, dec_kind, branch_taken, hazard_stall} = rows[i][12:7];
      sb.push_back(rows[i][6:0]);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL mid_wait[%0d] got=%b want=%b", i, got, want);
      end
    end
    #2;
    rst_n = 1'b0;
    sb.push_back(E_BOOT);
    #1;
    want = sb.pop_front();
    got  = obs();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL mid_wait_reset got=%b want=%b", got, want);
    end
`ifdef PC_SEQ_STATS_EN
    checks++;
    if ({stat_stalls, stat_redirects} !== 32'd0) begin
      failures++;
      $display("FAIL stats_reset got=%h/%h want=0/0", stat_stalls, stat_redirects);
    end
`endif
  endtask

  task automatic test_reset_mid_redirect();
    logic [12:0] rows[$];
    logic [6:0]  got;
    logic [6:0]  want;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rows.push_back(row(1, 0, 2'b00, 0, 0, E_BOOT));
    rows.push_back(row(1, 0, 2'b00, 0, 0, E_BOOT));
    rows.push_back(row(1, 1, 2'b10, 0, 0, E_JMP));
    rows.push_back(row(1, 0, 2'b00, 0, 0, E_REDIR));
    foreach (rows[i]) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      {imem_ready, dec_valid, dec_kind, branch_taken, hazard_stall} = rows[i][12:7];
      sb.push_back(rows[i][6:0]);
      @(negedge clk);
      want = sb.pop_front();
      got  = obs();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL mid_redirect[%0d] got=%b want=%b", i, got, want);
      end
    end
    #1;
    rst_n = 1'b0;
    sb.push_back(E_BOOT);
    #1;
    want = sb.pop_front();
    got  = obs();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL mid_redirect_reset got=%b want=%b", got, want);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_boot();
    test_jump();
    test_branch();
    test_back_to_back();
    test_hazard();
    test_ready_late();
    test_timeout();
    test_reset_mid_wait();
    test_reset_mid_redirect();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Sequencing controller for the next-PC unit. Each cycle it drives the PC source select, branch-test qualifier and stall that the NPC block consumes. It also owns the instruction-memory request handshake, boot hold-off, redirect bubbles and memory-timeout detection. It sits between the decode/hazard logic and the NPC/instruction-fetch datapath.

## Interface
Parameters:
- `RESET_HOLD`, default 2: cycles spent in BOOT after `rst_n` deasserts (≥1).
- `MEM_TIMEOUT`, default 15: max consecutive WAIT cycles before timeout (≥1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. One clock domain; reset asserts asynchronously, all state is reset while low.
- `imem_ready`  in  1  instruction memory delivers the word this cycle.
- `dec_valid`  in  1  decode stage holds a valid instruction.
- `dec_kind`  in  2  control-flow kind: 00 seq, 01 branch, 10 jump, 11 register jump (same codes as NPC select).
- `branch_taken`  in  1  branch condition result; meaningful only when `dec_kind`=01.
- `hazard_stall`  in  1  request from the hazard unit to freeze the PC.
- `npc_from`  out  2  PC source select to NPC.
- `branch_test`  out  1  branch qualifier to NPC.
- `stall`  out  1  freeze PC (NPC reloads the current PC).
- `imem_req`  out  1  fetch request.
- `flush`  out  1  kill the instruction in fetch/decode.
- `err`  out  1  sticky memory-timeout flag.

## Operation
- State register: BOOT, FETCH, WAIT, REDIRECT. Outputs are Mealy (state + current inputs). Defaults: `npc_from`=00, `branch_test`=0, `stall`=0, `imem_req`=0, `flush`=0.
- BOOT: `stall`=1. Count down `RESET_HOLD` cycles, then go to FETCH.
- FETCH: `imem_req`=1.
  - `imem_ready`=0: `stall`=1, go to WAIT, load the timeout counter with `MEM_TIMEOUT`.
  - Else if `hazard_stall`=1: `stall`=1, stay in FETCH. Hazard has priority over any redirect.
  - Else if `dec_valid`=1 and `dec_kind`≠00: `npc_from`=`dec_kind`, `branch_test`=`branch_taken`.
    - Jump, register jump, or taken branch: go to REDIRECT.
    - Not-taken branch: stay in FETCH.
  - Else: `npc_from`=00, stay in FETCH.
  - `dec_kind` is ignored while `dec_valid`=0.
- WAIT: `stall`=1, `imem_req`=1, counter decrements each cycle.
  - `imem_ready`=1: go to FETCH. `stall` stays 1 in this cycle.
  - Counter reaches 0 with no ready: set `err`=1 and go to FETCH, which retries the fetch.
- REDIRECT: `flush`=1, `stall`=1, `imem_req`=0 for exactly one cycle, then go to FETCH.
- `err` stays set until reset.

## Timing
- Reset values: state BOOT, `stall`=1, `imem_req`=0, `flush`=0, `npc_from`=00, `branch_test`=0, `err`=0, counters 0.
- First `imem_req`=1 occurs `RESET_HOLD` cycles after the first rising edge with `rst_n`=1.
- Redirect penalty is exactly 1 bubble cycle (REDIRECT).
- Timeout: `err` rises on the edge after the `MEM_TIMEOUT`-th consecutive WAIT cycle without ready.
- `imem_ready` arriving in the same cycle the timeout expires counts as success: `err` stays 0.
- Reset asserted mid-WAIT or mid-REDIRECT returns to BOOT immediately, with no residual `flush` or `err` update.
- Back-to-back redirects are allowed: FETCH→REDIRECT→FETCH→REDIRECT.

## Configuration
- `PC_SEQ_STATS_EN`: when defined, adds 16-bit saturating output counters `stat_stalls` and `stat_redirects`.
  - `stat_stalls` counts cycles with `stall`=1, excluding BOOT.
  - `stat_redirects` counts REDIRECT entries.
  - Both counters reset to 0.
- Without the macro, the counter ports and logic are absent and behaviour is otherwise identical.

## Structure
- Shared package/header `pc_seq_pkg`: NPC select encodings (PC4=00, BRANCH=01, JMP=10, REG=11), the state enumeration, and `dec_kind` codes. The NPC block uses the same encodings.
- Sub-module `seq_down_counter`: loadable down-counter with a zero flag. Parameterised on width and shared by the BOOT hold and the WAIT timeout.

## Test plan
- Release reset with `RESET_HOLD`=2 and `imem_ready`=1 → `stall`=1 for 2 cycles, then `imem_req`=1, `npc_from`=00, `stall`=0.
- In FETCH, `dec_valid`=1, `dec_kind`=10 → `npc_from`=10 in that cycle; next cycle `flush`=1, `stall`=1, `imem_req`=0; the following cycle is FETCH again.
- Branch with `branch_taken`=0 → `npc_from`=01, `branch_test`=0, no `flush`. Same input with `branch_taken`=1 → `branch_test`=1, followed by a REDIRECT cycle.
- `imem_ready` held 0 for 15 cycles, `MEM_TIMEOUT`=15 → `err`=1 and state returns to FETCH. Repeat with ready arriving in the 15th cycle → `err`=0.
- `hazard_stall`=1 together with `dec_kind`=11 → `stall`=1, `npc_from`=00, no redirect. When the hazard drops, the redirect proceeds.
- Assert `rst_n`=0 during WAIT → outputs immediately take their reset values. With `PC_SEQ_STATS_EN` defined, both stat counters read 0.
